// File: rtl/fifo_fwft_dp_ram_pkg.sv
// Shared configuration for the FWFT-capable DP-RAM FIFO: parameter defaults and
// the pointer-width helper used by the top level.
package fifo_fwft_dp_ram_pkg;

  localparam int DEF_FIFO_DEPTH   = 32;
  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_ALMOST_FULL  = 3;
  localparam int DEF_ALMOST_EMPTY = 3;
  localparam int DEF_FWFT         = 0;

  // One extra bit beyond the address acts as the wrap flag.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_fwft_dp_ram_simple_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port. The storage
// array has no reset; only the read register is cleared.
module simple_dp_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/fifo_fwft_dp_ram.sv
// Synchronous FIFO over a simple DP-RAM with optional first-word-fall-through,
// occupancy count, almost flags and sticky overflow/underflow.
module fifo_fwft_dp_ram
  import fifo_fwft_dp_ram_pkg::*;
#(
  parameter int FIFO_DEPTH         = DEF_FIFO_DEPTH,
  parameter int FIFO_DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ALMOST_FULL_DEPTH  = DEF_ALMOST_FULL,
  parameter int ALMOST_EMPTY_DEPTH = DEF_ALMOST_EMPTY,
  parameter int FWFT               = DEF_FWFT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         write,
  input  logic                         read,
  input  logic [FIFO_DATA_WIDTH-1:0]   write_data,
  output logic [FIFO_DATA_WIDTH-1:0]   read_data,
  output logic                         empty,
  output logic                         full,
  output logic                         almost_empty,
  output logic                         almost_full,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  input  logic                         clear_errors,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PW     = ptr_width(FIFO_DEPTH);

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] DEPTH_LVL = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] AF_LVL    = PW'(FIFO_DEPTH - ALMOST_FULL_DEPTH);
  localparam logic [PW-1:0] AE_LVL    = PW'(ALMOST_EMPTY_DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_overflow;
  logic          r_underflow;

  logic [PW-1:0] w_ram_cnt;
  logic [PW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_rd_ok;
  logic          w_wr_ok;
  logic          w_ram_rd_en;

  assign w_ram_cnt = r_wr_ptr - r_rd_ptr;
  assign w_full    = (w_count == DEPTH_LVL);
  assign w_rd_ok   = read & ~w_empty;
  assign w_wr_ok   = write & (~w_full | w_rd_ok);

  generate
    if (FWFT != 0) begin : g_fwft
      // The RAM read register doubles as the head-word register; r_valid marks it live.
      logic r_valid;

      assign w_ram_rd_en = (w_ram_cnt != '0) & (~r_valid | w_rd_ok);
      assign w_empty     = ~r_valid;
      assign w_count     = w_ram_cnt + {{ADDR_W{1'b0}}, r_valid};

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_valid <= 1'b0;
        end else if (w_ram_rd_en) begin
          r_valid <= 1'b1;
        end else if (w_rd_ok) begin
          r_valid <= 1'b0;
        end
      end
    end else begin : g_std
      assign w_ram_rd_en = w_rd_ok;
      assign w_empty     = (w_ram_cnt == '0);
      assign w_count     = w_ram_cnt;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_ram_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      // A new error in the same cycle wins over clear_errors.
      r_overflow  <= (r_overflow  & ~clear_errors) | (write & ~w_wr_ok);
      r_underflow <= (r_underflow & ~clear_errors) | (read & w_empty);
    end
  end

  simple_dp_ram #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_wr_ok),
    .wr_addr (r_wr_ptr[ADDR_W-1:0]),
    .wr_data (write_data),
    .rd_en   (w_ram_rd_en),
    .rd_addr (r_rd_ptr[ADDR_W-1:0]),
    .rd_data (read_data)
  );

  assign empty        = w_empty;
  assign full         = w_full;
  assign count        = w_count;
  assign almost_empty = (w_count <= AE_LVL);
  assign almost_full  = (w_count >= AF_LVL);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
